// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the memory stage: instruction codes, status codes,
// FSM state encoding and the data-memory range check.
package y86_pkg;

  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned ICODE_W    = 4;
  localparam int unsigned STAT_W     = 3;
  localparam int unsigned DATA_W     = 64;

  localparam logic [ICODE_W-1:0] IHALT   = 4'h0;
  localparam logic [ICODE_W-1:0] INOP    = 4'h1;
  localparam logic [ICODE_W-1:0] IRRMOVQ = 4'h2;
  localparam logic [ICODE_W-1:0] IIRMOVQ = 4'h3;
  localparam logic [ICODE_W-1:0] IRMMOVQ = 4'h4;
  localparam logic [ICODE_W-1:0] IMRMOVQ = 4'h5;
  localparam logic [ICODE_W-1:0] IOPQ    = 4'h6;
  localparam logic [ICODE_W-1:0] IJXX    = 4'h7;
  localparam logic [ICODE_W-1:0] ICALL   = 4'h8;
  localparam logic [ICODE_W-1:0] IRET    = 4'h9;
  localparam logic [ICODE_W-1:0] IPUSHQ  = 4'hA;
  localparam logic [ICODE_W-1:0] IPOPQ   = 4'hB;

  localparam logic [STAT_W-1:0] SAOK = 3'd1;
  localparam logic [STAT_W-1:0] SHLT = 3'd2;
  localparam logic [STAT_W-1:0] SADR = 3'd3;
  localparam logic [STAT_W-1:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // A full 8-byte word must fit; comparing against size-8 avoids addr+8 overflow.
  function automatic logic addr_in_range(input logic [DATA_W-1:0] addr,
                                         input int unsigned mem_bytes);
    return addr <= (DATA_W'(mem_bytes) - DATA_W'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/mem_op_decode.sv
// Combinational decode of an executed instruction into its data-memory operation
// (direction, address, write data) and the status it carries before any access.
module mem_op_decode
  import y86_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic [63:0] vala,
  input  logic [63:0] vale,
  input  logic [63:0] valp,
  output logic        is_mem,
  output logic        is_write,
  output logic [63:0] addr,
  output logic [63:0] wdata,
  output logic [2:0]  stat_pre
);

  always_comb begin
    is_mem   = 1'b0;
    is_write = 1'b0;
    addr     = vale;
    wdata    = vala;
    stat_pre = SAOK;
    case (icode)
      IHALT: stat_pre = SHLT;
      INOP, IRRMOVQ, IIRMOVQ, IOPQ, IJXX: stat_pre = SAOK;
      IRMMOVQ, IPUSHQ: begin
        is_mem   = 1'b1;
        is_write = 1'b1;
      end
      IMRMOVQ: is_mem = 1'b1;
      ICALL: begin
        is_mem   = 1'b1;
        is_write = 1'b1;
        wdata    = valp;
      end
      // ret and popq read from the old stack pointer
      IRET, IPOPQ: begin
        is_mem = 1'b1;
        addr   = vala;
      end
      default: stat_pre = SINS;
    endcase
  end

endmodule

// File: rtl/memory_stage_ctrl.sv
// Y86-64 SEQ memory stage: sequences one 64-bit data-memory access per instruction
// over a req/ack handshake and reports valm/stat with a one-cycle done pulse.
module memory_stage_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] vala,
  input  logic [63:0] vale,
  input  logic [63:0] valp,
  output logic        busy,
  output logic        done,
  output logic [63:0] valm,
  output logic [2:0]  stat,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        mem_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  logic [CNT_W-1:0]  tcnt;

  logic              dec_is_mem;
  logic              dec_is_write;
  logic [63:0]       dec_addr;
  logic [63:0]       dec_wdata;
  logic [2:0]        dec_stat;
  logic              in_range;

  mem_op_decode u_decode (
    .icode    (icode),
    .vala     (vala),
    .vale     (vale),
    .valp     (valp),
    .is_mem   (dec_is_mem),
    .is_write (dec_is_write),
    .addr     (dec_addr),
    .wdata    (dec_wdata),
    .stat_pre (dec_stat)
  );

  assign in_range = addr_in_range(dec_addr, MEM_BYTES);

  // Control FSM; done is raised on the edge that enters FINISH so it is visible there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valm      <= '0;
      stat      <= SAOK;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (dec_is_mem && in_range) begin
              mem_req   <= 1'b1;
              mem_we    <= dec_is_write;
              mem_addr  <= dec_addr;
              mem_wdata <= dec_wdata;
              busy      <= 1'b1;
              tcnt      <= '0;
              state     <= S_ACCESS;
            end else begin
              stat  <= dec_is_mem ? SADR : dec_stat;
              done  <= 1'b1;
              state <= S_FINISH;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_FINISH;
            if (mem_err) begin
              stat <= SADR;
            end else begin
              stat <= SAOK;
              if (!mem_we) valm <= mem_rdata;
            end
          end else if (tcnt == CNT_LAST) begin
            // No response within the budget: treat as a bad address
            mem_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            stat    <= SADR;
            state   <= S_FINISH;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_stage_ctrl.md
Name: memory_stage_ctrl

Overview:
- Sequential memory stage directly downstream of the execute stage in the Y86-64 SEQ datapath.
- Takes icode, vala, vale and valp from execute, then runs one 64-bit data-memory access per instruction over a req/ack handshake to the data memory.
- Returns valm and the instruction status to write-back/PC-update.
- Owns the start/done sequencing so the rest of the processor can stall on slow memory.

Parameters:
- MEM_BYTES, 8192: data memory size in bytes; legal access when addr + 8 <= MEM_BYTES.
- TIMEOUT, 16: cycles to wait for mem_ack before declaring an address error.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse: execute outputs valid this cycle
- icode  input  4  instruction code
- vala  input  64  register A value
- vale  input  64  ALU result from execute
- valp  input  64  incremented PC
- busy  output  1  high from cycle after accepted start until done
- done  output  1  one-cycle pulse: valm/stat valid
- valm  output  64  read data (last read value held)
- stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- mem_req  output  1  data-memory request
- mem_we  output  1  1=write, 0=read
- mem_addr  output  64  byte address
- mem_wdata  output  64  write data
- mem_rdata  input  64  read data, valid with mem_ack
- mem_ack  input  1  memory completes the request this cycle
- mem_err  input  1  memory fault, valid with mem_ack

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, valm=0, stat=1 (AOK), mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. FSM goes to IDLE and the timeout counter clears.
- FSM states: IDLE, ACCESS, FINISH.
- Per-icode operation, decoded on the start cycle:
  - 4 (rmmovq): write, addr=vale, data=vala.
  - 5 (mrmovq): read, addr=vale.
  - 8 (call): write, addr=vale, data=valp.
  - 9 (ret): read, addr=vala.
  - 10 (pushq): write, addr=vale, data=vala.
  - 11 (popq): read, addr=vala.
  - 0 (halt): no access, stat=HLT.
  - 1, 2, 3, 6, 7: no access, stat=AOK.
  - 12-15: no access, stat=INS.
- IDLE + start, memory icode, in range: latch addr/we/wdata, assert mem_req next cycle, go to ACCESS, busy=1.
- IDLE + start, memory icode, out of range (addr > MEM_BYTES-8, unsigned 64-bit compare, no overflow on addr+8): no request; go to FINISH with stat=ADR.
- IDLE + start, non-memory icode: go to FINISH with the stat from the decode above.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ack is sampled high.
  - On ack: drop mem_req the next cycle. On a read without error, valm<=mem_rdata. stat=ADR if mem_err, else AOK. Go to FINISH.
  - Timeout counter increments each ACCESS cycle without ack. On reaching TIMEOUT: drop req, stat=ADR, go to FINISH, valm unchanged.
- FINISH: done=1 for exactly one cycle, busy=0, return to IDLE. A start in FINISH is ignored.
- Latency:
  - Non-memory or out-of-range: done 1 cycle after start.
  - Memory access: mem_req 1 cycle after start; done 1 cycle after the ack cycle. Zero-wait memory therefore gives done 2 cycles after start.
- start while busy is ignored and no state is corrupted.
- Write operations never modify valm. Error cases never modify valm.
- mem_ack outside ACCESS is ignored.
- stat holds its last value between instructions.
- rst mid-ACCESS: mem_req low after that edge, no done pulse, outputs at reset values.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=10, IPOPQ=11.
  - stat constants: SAOK=1, SHLT=2, SADR=3, SINS=4.
  - FSM state encoding.
- One combinational sub-module, mem_op_decode: icode/vala/vale/valp in; is_mem, is_write, addr, wdata and the pre-access stat out. The FSM instantiates it.

Test Plan:
- rmmovq, icode=4, vale=0x100, vala=0xDEADBEEF, ack 3 cycles after req -> mem_req held 3 cycles with we=1, addr=0x100, wdata=0xDEADBEEF; done 1 cycle after ack; stat=1; valm unchanged.
- mrmovq, icode=5, vale=0x40, zero-wait memory, mem_rdata=0x1234 -> done 2 cycles after start; valm=0x1234; stat=1. Then popq, icode=11, vala=0x48 -> addr=0x48, read.
- Out-of-range mrmovq, vale=MEM_BYTES-7=8185 -> no mem_req; done next cycle; stat=3. Boundary case vale=8184 -> access issued.
- No ack -> mem_req held exactly TIMEOUT=16 cycles, then dropped; done; stat=3. Separately, ack with mem_err=1 -> stat=3, valm unchanged.
- icode=0 -> done next cycle, stat=2. icode=13 -> stat=4. icode=6 -> stat=1. None issue mem_req.
- rst asserted during ACCESS -> next cycle mem_req=0, busy=0, no done, stat=1. A second start while busy -> ignored, no extra done pulse.
